exu_oitf: RTL

//  Outstanding Instruction Track FIFO: the in-order scoreboard that exu_disp consults before issuing.

---
 rtl/exu_oitf_if.sv | 41 ++++
 rtl/exu_oitf.sv | 103 ++++++++++
 2 files changed

// File: rtl/exu_oitf_if.sv
// rtl/exu_oitf_if.sv - dispatch/retire port bundle of the outstanding instruction track FIFO.
interface exu_oitf_if #(
  parameter int ITAG_WIDTH  = 2,
  parameter int RFIDX_WIDTH = 5,
  parameter int PC_SIZE     = 32
);
  logic                   disp_oitf_ena;
  logic                   disp_oitf_ready;
  logic [ITAG_WIDTH-1:0]  disp_oitf_ptr;
  logic                   disp_oitf_rs1en;
  logic                   disp_oitf_rs2en;
  logic                   disp_oitf_rdwen;
  logic [RFIDX_WIDTH-1:0] disp_oitf_rs1idx;
  logic [RFIDX_WIDTH-1:0] disp_oitf_rs2idx;
  logic [RFIDX_WIDTH-1:0] disp_oitf_rdidx;
  logic [PC_SIZE-1:0]     disp_oitf_pc;
  logic                   oitfrd_match_disprs1;
  logic                   oitfrd_match_disprs2;
  logic                   oitfrd_match_disprd;
  logic                   ret_ena;
  logic [ITAG_WIDTH-1:0]  ret_ptr;
  logic                   ret_rdwen;
  logic [RFIDX_WIDTH-1:0] ret_rdidx;
  logic [PC_SIZE-1:0]     ret_pc;
  logic                   oitf_empty;
  logic                   oitf_err;

  modport master (
    output disp_oitf_ena, disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen,
           disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx, disp_oitf_pc, ret_ena,
    input  disp_oitf_ready, disp_oitf_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprd, ret_ptr, ret_rdwen, ret_rdidx, ret_pc, oitf_empty, oitf_err
  );

  modport slave (
    input  disp_oitf_ena, disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen,
           disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx, disp_oitf_pc, ret_ena,
    output disp_oitf_ready, disp_oitf_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
           oitfrd_match_disprd, ret_ptr, ret_rdwen, ret_rdidx, ret_pc, oitf_empty, oitf_err
  );
endinterface

// File: rtl/exu_oitf.sv
// rtl/exu_oitf.sv - in-order scoreboard of outstanding long-pipe instructions with RAW/WAW hazard match.
module exu_oitf #(
  parameter int DEPTH       = 4,
  parameter int ITAG_WIDTH  = 2,
  parameter int RFIDX_WIDTH = 5,
  parameter int PC_SIZE     = 32
) (
  input logic       clk,
  input logic       rst,
  exu_oitf_if.slave oitf
);
  logic [ITAG_WIDTH-1:0]  alloc_ptr;
  logic [ITAG_WIDTH-1:0]  ret_ptr;
  logic                   alloc_flg;
  logic                   ret_flg;
  logic [DEPTH-1:0]       valid;
  logic [DEPTH-1:0]       ent_rdwen;
  logic [RFIDX_WIDTH-1:0] ent_rdidx [DEPTH];
  logic [PC_SIZE-1:0]     ent_pc    [DEPTH];
  logic                   err;

  logic empty, full;
  logic alloc_fire, ret_fire, alloc_bad, ret_bad;
  logic hit_rs1, hit_rs2, hit_rd;

  // Wrap flags disambiguate the equal-pointer case into empty vs. full.
  assign empty = (alloc_ptr == ret_ptr) && (alloc_flg == ret_flg);
  assign full  = (alloc_ptr == ret_ptr) && (alloc_flg != ret_flg);

  assign alloc_fire = oitf.disp_oitf_ena & ~full;
  assign ret_fire   = oitf.ret_ena & ~empty;
  assign alloc_bad  = oitf.disp_oitf_ena & full;
  assign ret_bad    = oitf.ret_ena & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      ret_ptr   <= '0;
      alloc_flg <= 1'b0;
      ret_flg   <= 1'b0;
      valid     <= '0;
      ent_rdwen <= '0;
      err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rdidx[i] <= '0;
        ent_pc[i]    <= '0;
      end
    end else begin
      if (alloc_fire) begin
        valid[alloc_ptr]     <= 1'b1;
        ent_rdwen[alloc_ptr] <= oitf.disp_oitf_rdwen;
        ent_rdidx[alloc_ptr] <= oitf.disp_oitf_rdidx;
        ent_pc[alloc_ptr]    <= oitf.disp_oitf_pc;
        if (alloc_ptr == ITAG_WIDTH'(DEPTH - 1)) begin
          alloc_ptr <= '0;
          alloc_flg <= ~alloc_flg;
        end else begin
          alloc_ptr <= alloc_ptr + 1'b1;
        end
      end
      // Alloc and retire never target the same slot: that needs equal pointers, i.e. full or empty.
      if (ret_fire) begin
        valid[ret_ptr] <= 1'b0;
        if (ret_ptr == ITAG_WIDTH'(DEPTH - 1)) begin
          ret_ptr <= '0;
          ret_flg <= ~ret_flg;
        end else begin
          ret_ptr <= ret_ptr + 1'b1;
        end
      end
      if (alloc_bad | ret_bad) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && ent_rdwen[i]) begin
        if (ent_rdidx[i] == oitf.disp_oitf_rs1idx) hit_rs1 = 1'b1;
        if (ent_rdidx[i] == oitf.disp_oitf_rs2idx) hit_rs2 = 1'b1;
        if (ent_rdidx[i] == oitf.disp_oitf_rdidx)  hit_rd  = 1'b1;
      end
    end
  end

  // x0 is hardwired, so a dependency through it is never a hazard.
  assign oitf.oitfrd_match_disprs1 = oitf.disp_oitf_rs1en && (oitf.disp_oitf_rs1idx != '0) && hit_rs1;
  assign oitf.oitfrd_match_disprs2 = oitf.disp_oitf_rs2en && (oitf.disp_oitf_rs2idx != '0) && hit_rs2;
  assign oitf.oitfrd_match_disprd  = oitf.disp_oitf_rdwen && (oitf.disp_oitf_rdidx  != '0) && hit_rd;

  assign oitf.disp_oitf_ready = ~full;
  assign oitf.disp_oitf_ptr   = alloc_ptr;
  assign oitf.ret_ptr         = ret_ptr;
  assign oitf.ret_rdwen       = ent_rdwen[ret_ptr];
  assign oitf.ret_rdidx       = ent_rdidx[ret_ptr];
  assign oitf.ret_pc          = ent_pc[ret_ptr];
  assign oitf.oitf_empty      = empty;
  assign oitf.oitf_err        = err;
endmodule
